// File: rtl/fifo_fetch_ctrl.sv
// fifo_fetch_ctrl
//   Refill sequencer for the pixel-path sync_fifo. It fetches packed pixel
//   words from frame memory over a req/ack handshake and writes them into the
//   FIFO, while the pixel-side consumer drains the FIFO on its own. The block
//   keeps its own occupancy count, applies low-watermark hysteresis, walks the
//   frame address space with wrap, flushes the FIFO at frame start and raises
//   a sticky underrun flag.
//
// Ports
//   clk             system clock
//   clr_n_in        asynchronous active-low reset
//   enable_in       fetch enable (level)
//   frame_start_in  one-cycle pulse: flush FIFO, restart address at 0
//   mem_req_out     memory read request, held until mem_ack_in
//   mem_addr_out    frame-memory word address, stable while requesting
//   mem_ack_in      request accepted, mem_data_in valid this cycle
//   mem_data_in     read data
//   fifo_we_out     FIFO write enable
//   fifo_data_out   FIFO write data
//   fifo_clr_n_out  FIFO clear, active-low
//   fifo_rd_in      consumer read strobe (observed)
//   fifo_full_in    FIFO full flag
//   fifo_empty_in   FIFO empty flag
//   level_out       tracked FIFO occupancy
//   frame_done_out  one-cycle pulse after the last word of a frame is fetched
//   underrun_out    sticky: consumer read an empty FIFO
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled, no requests
// FLUSH   | one cycle: FIFO clear, level/address/underrun reset
// FETCH   | request outstanding, waiting for ack
// WRITE   | one cycle: captured word written into the FIFO
// WAIT    | FIFO full, waiting for level to fall to the low watermark

module fifo_fetch_ctrl #(
    parameter int FIFO_WIDTH    = 36,
    parameter int FIFO_DEPTH    = 10,
    parameter int ADDR_WIDTH    = 17,
    parameter int FRAME_WORDS   = 102400,
    parameter int LOW_WATERMARK = 4,
    localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  clr_n_in,
    input  logic                  enable_in,
    input  logic                  frame_start_in,
    output logic                  mem_req_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic                  mem_ack_in,
    input  logic [FIFO_WIDTH-1:0] mem_data_in,
    output logic                  fifo_we_out,
    output logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_clr_n_out,
    input  logic                  fifo_rd_in,
    input  logic                  fifo_full_in,
    input  logic                  fifo_empty_in,
    output logic [LVL_W-1:0]      level_out,
    output logic                  frame_done_out,
    output logic                  underrun_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    fs_pend_q;
    logic                    fs_pend_d;
    logic                    fs_any;
    logic                    last_addr;
    logic                    lvl_inc;
    logic                    lvl_dec;
    logic [LVL_W-1:0]        level_nxt;

    logic                    req_d;
    logic                    we_d;
    logic                    clr_n_d;
    logic                    done_d;
    logic                    underrun_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [FIFO_WIDTH-1:0]   data_d;
    logic [LVL_W-1:0]        level_d;

    // A frame start seen earlier in this fetch, or arriving right now.
    assign fs_any    = fs_pend_q | frame_start_in;
    assign last_addr = (mem_addr_out == ADDR_WIDTH'(FRAME_WORDS - 1));

    // Occupancy after this cycle's write/read; a read at level 0 is an
    // underrun and must not wrap the count.
    always_comb begin
        lvl_inc   = fifo_we_out;
        lvl_dec   = fifo_rd_in && (level_out != '0);
        level_nxt = level_out;
        if (lvl_inc && !lvl_dec) begin
            level_nxt = level_out + 1'b1;
        end else if (!lvl_inc && lvl_dec) begin
            level_nxt = level_out - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n_in) begin
        if (!clr_n_in) begin
            state_q        <= ST_IDLE;
            fs_pend_q      <= 1'b0;
            mem_req_out    <= 1'b0;
            mem_addr_out   <= '0;
            fifo_we_out    <= 1'b0;
            fifo_data_out  <= '0;
            fifo_clr_n_out <= 1'b0;
            level_out      <= '0;
            frame_done_out <= 1'b0;
            underrun_out   <= 1'b0;
        end else begin
            state_q        <= state_d;
            fs_pend_q      <= fs_pend_d;
            mem_req_out    <= req_d;
            mem_addr_out   <= addr_d;
            fifo_we_out    <= we_d;
            fifo_data_out  <= data_d;
            fifo_clr_n_out <= clr_n_d;
            level_out      <= level_d;
            frame_done_out <= done_d;
            underrun_out   <= underrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_in) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = enable_in ? ST_FETCH : ST_IDLE;
            end
            ST_FETCH: begin
                // The request is never withdrawn; enable only matters after
                // the word has been written.
                if (mem_ack_in) state_d = fs_any ? ST_FLUSH : ST_WRITE;
            end
            ST_WRITE: begin
                if (fs_any)                                    state_d = ST_FLUSH;
                else if (!enable_in)                           state_d = ST_IDLE;
                else if (level_nxt == LVL_W'(FIFO_DEPTH))      state_d = ST_WAIT;
                else                                           state_d = ST_FETCH;
            end
            ST_WAIT: begin
                if (frame_start_in)                            state_d = ST_FLUSH;
                else if (!enable_in)                           state_d = ST_IDLE;
                else if (level_out <= LVL_W'(LOW_WATERMARK))   state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being
    // entered; this keeps mem_req_out/fifo_we_out aligned with FETCH/WRITE.
    always_comb begin
        req_d      = (state_d == ST_FETCH);
        we_d       = (state_d == ST_WRITE);
        clr_n_d    = (state_d != ST_FLUSH);
        addr_d     = mem_addr_out;
        data_d     = fifo_data_out;
        done_d     = 1'b0;
        level_d    = level_nxt;
        underrun_d = underrun_out | (fifo_rd_in & fifo_empty_in & (state_q != ST_IDLE));
        fs_pend_d  = fs_pend_q;

        if (state_q == ST_FETCH) begin
            if (frame_start_in) fs_pend_d = 1'b1;
            // A word acked under a pending frame start is dropped and the
            // address is left for the flush to zero.
            if (mem_ack_in && !fs_any) begin
                data_d = mem_data_in;
                if (last_addr) begin
                    addr_d = '0;
                    done_d = 1'b1;
                end else begin
                    addr_d = mem_addr_out + 1'b1;
                end
            end
        end

        if (state_d == ST_FLUSH) begin
            addr_d     = '0;
            level_d    = '0;
            underrun_d = 1'b0;
            fs_pend_d  = 1'b0;
        end
    end

`ifndef SYNTHESIS
    // The tracked level must agree with the FIFO's own flags, except while
    // the FIFO is being cleared (its contents are stale in the flush cycle).
    always @(posedge clk) begin
        if (clr_n_in && fifo_clr_n_out) begin
            assert ((level_out == '0) == fifo_empty_in)
                else $error("level_out disagrees with fifo_empty_in");
            assert ((level_out == LVL_W'(FIFO_DEPTH)) == fifo_full_in)
                else $error("level_out disagrees with fifo_full_in");
        end
    end
`endif

endmodule
